// File: rtl/fpu_result_capture.sv
// ============================================================================
// Module   : fpu_result_capture
// Captures the FPU result stream and exception flags into a result memory,
// aligned to the FPU pipeline latency, with a synchronous read-back port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fpu_result_capture #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              op_valid,
    input  logic [15:0]       result,
    input  logic              overflow,
    input  logic              underflow,
    input  logic              inexact,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [18:0]       rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   wr_count,
    output logic              busy,
    output logic              done,
    output logic              dropped
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [2:0]      C_LAT   = 3'(LATENCY);

    state_t              state_q, state_d;
    logic [LATENCY-1:0]  vld_sr_q, vld_sr_d;
    logic [2:0]          drain_q, drain_d;
    logic [ADDR_W:0]     wr_count_q, wr_count_d;
    logic                dropped_q, dropped_d;
    logic [18:0]         rd_data_q;
    logic                rd_valid_q;
    logic [18:0]         mem [DEPTH];

    logic w_vld_aligned;
    logic w_full;
    logic w_wr_en;

    assign w_vld_aligned = vld_sr_q[LATENCY-1];
    assign w_full        = (wr_count_q == C_DEPTH);
    assign w_wr_en       = w_vld_aligned && !w_full;

    always_comb begin
        state_d    = state_q;
        vld_sr_d   = vld_sr_q << 1;
        drain_d    = drain_q;
        wr_count_d = wr_count_q + {{ADDR_W{1'b0}}, w_wr_en};
        dropped_d  = dropped_q | (w_vld_aligned & w_full);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_CAPTURE;
                    vld_sr_d   = '0;
                    wr_count_d = '0;
                    dropped_d  = 1'b0;
                end
            end
            S_CAPTURE: begin
                // Only ops issued while capturing enter the alignment pipe
                vld_sr_d = (vld_sr_q << 1) | LATENCY'(op_valid);
                if (stop) begin
                    state_d = S_DRAIN;
                    drain_d = C_LAT;
                end
            end
            S_DRAIN: begin
                if (drain_q == 3'd0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            vld_sr_q   <= '0;
            drain_q    <= 3'd0;
            wr_count_q <= '0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vld_sr_q   <= vld_sr_d;
            drain_q    <= drain_d;
            wr_count_q <= wr_count_d;
            dropped_q  <= dropped_d;
        end
    end

    // Result memory is not reset; entries persist across runs until overwritten
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[wr_count_q[ADDR_W-1:0]] <= {overflow, underflow, inexact, result};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= mem[rd_addr];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign wr_count = wr_count_q;
    assign busy     = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign dropped  = dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_result_capture.sv
// ============================================================================
// Module   : tb_fpu_result_capture
// Directed and randomized capture runs on a deep and a 4-entry instance,
// compared against a run-level reference model of expected memory contents.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fpu_result_capture;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset, start, stop, op_valid, ov, un, ix, rd_en;
    logic [15:0] result;
    logic [7:0]  rd_addr;

    logic [18:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic [8:0]  wr_count_a;
    logic [2:0]  wr_count_b;
    logic        busy_a, busy_b, done_a, done_b, dropped_a, dropped_b;

    fpu_result_capture #(.DEPTH(256), .ADDR_W(8), .LATENCY(LAT)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .op_valid(op_valid),
        .result(result), .overflow(ov), .underflow(un), .inexact(ix),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .wr_count(wr_count_a), .busy(busy_a), .done(done_a), .dropped(dropped_a)
    );

    fpu_result_capture #(.DEPTH(4), .ADDR_W(2), .LATENCY(LAT)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .op_valid(op_valid),
        .result(result), .overflow(ov), .underflow(un), .inexact(ix),
        .rd_en(rd_en), .rd_addr(rd_addr[1:0]), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .wr_count(wr_count_b), .busy(busy_b), .done(done_b), .dropped(dropped_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [18:0] val;
    } pend_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    pend_t       pend[$];
    logic [18:0] run_q[$];
    logic [18:0] vals_q[$];
    bit          pat_q[$];
    logic [18:0] mem_a [256];
    logic [18:0] mem_b [4];
    bit          capturing = 1'b0;
    logic [18:0] last_rd;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then present the FPU result due at the following edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (pend.size() > 0 && pend[0].due == cyc + 1) begin
            {ov, un, ix, result} = pend[0].val;
            void'(pend.pop_front());
        end else begin
            {ov, un, ix, result} = 19'($urandom);
        end
    endtask

    task automatic cycle(input bit v, input logic [18:0] val, input bit st, input bit sp);
        pend_t p;
        op_valid = v;
        start    = st;
        stop     = sp;
        if (v) begin
            p.due = cyc + 1 + LAT;
            p.val = val;
            pend.push_back(p);
            if (capturing) run_q.push_back(val);
        end
        if (st && !capturing) begin
            capturing = 1'b1;
            run_q.delete();
        end else if (sp && capturing) begin
            capturing = 1'b0;
        end
        step();
        op_valid = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
    endtask

    task automatic read_check(input int a);
        rd_en   = 1'b1;
        rd_addr = 8'(a);
        cycle(1'b0, 19'd0, 1'b0, 1'b0);
        rd_en   = 1'b0;
        check("rd_valid", {31'd0, rd_valid_a}, 32'd1);
        check("rd_data_a", {13'd0, rd_data_a}, {13'd0, mem_a[a]});
        if (a < 4) check("rd_data_b", {13'd0, rd_data_b}, {13'd0, mem_b[a]});
        last_rd = mem_a[a];
    endtask

    task automatic finish_run();
        int n;
        for (int i = 1; i <= LAT + 1; i++) begin
            step();
            check("done_timing", {31'd0, done_a}, {31'd0, (i == LAT + 1)});
        end
        check("done_b", {31'd0, done_b}, 32'd1);
        check("busy_after_done", {31'd0, busy_a}, 32'd0);
        n = run_q.size();
        check("wr_count_a", {23'd0, wr_count_a}, 32'(imin(n, 256)));
        check("wr_count_b", {29'd0, wr_count_b}, 32'(imin(n, 4)));
        check("dropped_a", {31'd0, dropped_a}, {31'd0, (n > 256)});
        check("dropped_b", {31'd0, dropped_b}, {31'd0, (n > 4)});
        for (int i = 0; i < imin(n, 256); i++) mem_a[i] = run_q[i];
        for (int i = 0; i < imin(n, 4); i++) mem_b[i] = run_q[i];
        for (int i = 0; i < imin(n, 256); i++) read_check(i);
    endtask

    // Start, walk the issue pattern (stop rides on the last slot), then drain
    task automatic do_run();
        int k = 0;
        cycle(1'b0, 19'd0, 1'b1, 1'b0);
        check("busy_after_start", {31'd0, busy_a}, 32'd1);
        for (int i = 0; i < pat_q.size(); i++) begin
            if (pat_q[i]) begin
                cycle(1'b1, vals_q[k], 1'b0, (i == pat_q.size() - 1));
                k++;
            end else begin
                cycle(1'b0, 19'd0, 1'b0, (i == pat_q.size() - 1));
            end
        end
        finish_run();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_count"}, {23'd0, wr_count_a}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
        check({tag, "_done"}, {31'd0, done_a}, 32'd0);
        check({tag, "_dropped"}, {31'd0, dropped_a}, 32'd0);
        check({tag, "_rd_valid"}, {31'd0, rd_valid_a}, 32'd0);
        check({tag, "_rd_data"}, {13'd0, rd_data_a}, 32'd0);
        check({tag, "_wr_count_b"}, {29'd0, wr_count_b}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; op_valid = 1'b0;
        rd_en = 1'b0; rd_addr = 8'd0; {ov, un, ix, result} = 19'($urandom);
        repeat (2) @(posedge clk);
        #3;
        check_reset_values("reset");
        reset = 1'b0;

        // A stray op and a stop while idle must leave nothing behind
        cycle(1'b1, 19'h12345, 1'b0, 1'b1);
        repeat (LAT + 1) step();
        check("idle_wr_count", {23'd0, wr_count_a}, 32'd0);
        check("idle_busy", {31'd0, busy_a}, 32'd0);

        // Basic run
        vals_q = '{19'h03C00, 19'h04000, 19'h04200, 19'h04400};
        pat_q  = '{1'b1, 1'b1, 1'b1, 1'b1};
        do_run();
        check("basic_addr3", {13'd0, last_rd}, 32'h04400);

        // Flag packing: overflow and inexact set
        vals_q = '{{1'b1, 1'b0, 1'b1, 16'h7C00}};
        pat_q  = '{1'b1};
        do_run();
        check("flag_pack", {13'd0, rd_data_a}, 32'h57C00);

        // Gapped issue
        vals_q.delete();
        for (int i = 0; i < 4; i++) vals_q.push_back(19'($urandom));
        pat_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_run();

        // Overfill the 4-entry instance
        vals_q.delete();
        pat_q.delete();
        for (int i = 0; i < 6; i++) begin
            vals_q.push_back(19'($urandom));
            pat_q.push_back(1'b1);
        end
        do_run();

        // Randomized runs with random gaps, lengths and flags
        for (int r = 0; r < 6; r++) begin
            int len = $urandom_range(1, 12);
            vals_q.delete();
            pat_q.delete();
            for (int i = 0; i < len; i++) begin
                bit b = ($urandom_range(0, 2) != 0);
                pat_q.push_back(b);
                if (b) vals_q.push_back(19'($urandom));
            end
            do_run();
        end

        // rd_data holds while rd_en is low
        cycle(1'b0, 19'd0, 1'b0, 1'b0);
        check("rd_hold", {13'd0, rd_data_a}, {13'd0, last_rd});
        check("rd_valid_low", {31'd0, rd_valid_a}, 32'd0);

        // Reset in the middle of a capture run after two writes
        cycle(1'b0, 19'd0, 1'b1, 1'b0);
        cycle(1'b1, 19'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 19'($urandom), 1'b0, 1'b0);
        repeat (LAT) cycle(1'b0, 19'd0, 1'b0, 1'b0);
        check("pre_reset_wr_count", {23'd0, wr_count_a}, 32'd2);
        #2 reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        capturing = 1'b0;
        pend.delete();
        run_q.delete();
        #1 reset = 1'b0;

        // start and stop together in IDLE: start wins
        cycle(1'b0, 19'd0, 1'b1, 1'b1);
        check("start_wins_busy", {31'd0, busy_a}, 32'd1);
        cycle(1'b1, 19'($urandom), 1'b0, 1'b1);
        finish_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fpu_result_capture.md
# fpu_result_capture

Captures the 16-bit FPU result stream and its exception flags into an on-chip result memory, one entry per issued operation, aligned to the FPU pipeline latency. It is the write-side counterpart of the operation memory that feeds the FPU: the op memory supplies operands by address, and this block records results by the same index. A synchronous read port lets a bench or scan path dump the captured entries after or during a run.

## Interface
- DEPTH, 256: number of result entries (power of two).
- ADDR_W, 8: log2(DEPTH).
- LATENCY, 2: cycles from op_valid high to the matching result/flags being valid at the inputs (1..4).

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle pulse; begins a capture run.
- stop  in  1  one-cycle pulse; no further ops are issued; drain in-flight results.
- op_valid  in  1  an operation is presented to the FPU this cycle.
- result  in  16  FPU result.
- overflow, underflow, inexact  in  1 each  FPU exception flags.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read index.
- rd_data  out  19  {overflow, underflow, inexact, result} at rd_addr.
- rd_valid  out  1  rd_data valid this cycle.
- wr_count  out  ADDR_W+1  entries written in the current run.
- busy  out  1  state is CAPTURE or DRAIN.
- done  out  1  state is DONE.
- dropped  out  1  sticky; a valid result arrived while memory was full.

## Operation
- Alignment: LATENCY-stage shift register carries op_valid; its last stage (vld_aligned) qualifies writes. The shift register is loaded only in CAPTURE; it shifts 0 in DRAIN and is cleared on entry to CAPTURE.
- Write: when vld_aligned and wr_count < DEPTH, mem[wr_count[ADDR_W-1:0]] <= {overflow, underflow, inexact, result}; wr_count increments. When vld_aligned and wr_count == DEPTH, no write occurs, dropped <= 1, and wr_count holds.
- States:
  - IDLE: start -> CAPTURE (wr_count <= 0, dropped <= 0).
  - CAPTURE: stop -> DRAIN (drain counter <= LATENCY). If wr_count reaches DEPTH with no stop pending, stay in CAPTURE and set dropped on further results.
  - DRAIN: writes continue from the shift register; drain counter decrements each cycle; at 0 -> DONE.
  - DONE: holds until start -> CAPTURE (restart: count cleared, memory contents kept until overwritten).
- start during CAPTURE or DRAIN is ignored. stop in IDLE or DONE is ignored. start and stop in the same cycle in IDLE: start wins, and stop is ignored.
- Read port: always enabled regardless of state. rd_data <= mem[rd_addr] on a clock edge with rd_en high; rd_valid <= rd_en. A read and a write to the same address in the same cycle returns the old contents.
- rd_data holds its last value when rd_en is low.

## Timing
- Reset values: state IDLE, wr_count 0, busy 0, done 0, dropped 0, rd_valid 0, rd_data 0, shift register 0. Memory is not reset.
- An op issued at edge N with op_valid high has its result written at edge N+LATENCY. wr_count reflects the write on the following cycle.
- busy rises in the cycle after the start edge. done rises exactly LATENCY+1 cycles after the stop edge.
- Read latency is 1 cycle: rd_addr/rd_en sampled at edge N produce rd_data/rd_valid valid after edge N.
- Reset asserted mid-run returns to IDLE at once. Results in flight are discarded, and a later start begins a fresh run.

## Test plan
- Basic run: LATENCY=2, start, then 4 ops with results 0x3C00, 0x4000, 0x4200, 0x4400 and flags 000, then stop. Required: done after LATENCY+1 cycles, wr_count=4, and reads of addresses 0..3 return 19'h03C00, 04000, 04200, 04400.
- Flag packing: one op with result 0x7C00, overflow=1, inexact=1. Required: rd_data = 19'h57C00 (bits 18 and 16 set).
- Gapped issue: op_valid pattern 1,0,1,1,0,1. Required: exactly 4 entries written in order, and no entries are written for idle cycles.
- Full: DEPTH=4, 6 ops issued. Required: wr_count=4, dropped=1, and entries 0..3 equal the first four results.
- Stop drain: stop issued in the same cycle as the last op_valid. Required: that op's result is still written, and done follows LATENCY+1 cycles later.
- Reset mid-CAPTURE after 2 writes, then start and 1 op. Required: all outputs return to their reset values immediately, then wr_count=1 after the new run, with the new result at address 0.
